// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions.
// Opcode encoding and default latencies for ID decode, hazard and EX.
package mult_div_unit_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_OP_NONE  = 3'd0;
    localparam md_op_t MD_OP_MULT  = 3'd1;
    localparam md_op_t MD_OP_MULTU = 3'd2;
    localparam md_op_t MD_OP_DIV   = 3'd3;
    localparam md_op_t MD_OP_DIVU  = 3'd4;
    localparam md_op_t MD_OP_MTHI  = 3'd5;
    localparam md_op_t MD_OP_MTLO  = 3'd6;
    localparam md_op_t MD_OP_RSVD  = 3'd7;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage multiply/divide request and result bundle.
// master: EX issue side (start/op/operands); slave: the MD unit (busy/hi/lo).
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        start;
    md_op_t      op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_md_core.sv
// Combinational 32x32 multiply and divide datapath.
// In: a, b, sgn. Out: 64-bit prod, quot, rem, div_zero.
module md_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];

        // Low 64 bits of the product of sign-extended
        // operands equal the signed product.
        a_ext = {{32{a_neg}}, a};
        b_ext = {{32{b_neg}}, b};
        prod  = a_ext * b_ext;

        // Signed divide via magnitudes; -2^31 magnitude
        // stays 0x80000000, so MIN / -1 yields MIN.
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = (b == 32'd0);
        b_div    = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_div;
        r_mag    = a_mag % b_div;

        quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem  = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage MIPS multiply/divide unit holding HI/LO.
// Ports: clk, reset (sync, high), md (slave: start/op/rs/rt in, busy/hi/lo out).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave md
);

    localparam int MAX_CYC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   p_hi;
    logic [31:0]   p_lo;
    logic          p_ok;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    logic          is_mul;
    logic          is_div;
    logic          is_mthi;
    logic          is_mtlo;
    logic          is_sgn;
    logic [63:0]   prod;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic          div_zero;

    always_comb begin
        is_mul  = (md.op == MD_OP_MULT) ||
                  (md.op == MD_OP_MULTU);
        is_div  = (md.op == MD_OP_DIV) ||
                  (md.op == MD_OP_DIVU);
        is_mthi = (md.op == MD_OP_MTHI);
        is_mtlo = (md.op == MD_OP_MTLO);
        is_sgn  = md_is_signed(md.op);
    end

    md_core u_core (
        .a        (md.rs_val),
        .b        (md.rt_val),
        .sgn      (is_sgn),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            p_ok  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state == RUN) begin
            // Starts are ignored while running.
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state <= IDLE;
                if (p_ok) begin
                    hi_q <= p_hi;
                    lo_q <= p_lo;
                end
            end
        end else if (md.start) begin
            unique case (1'b1)
                is_mul: begin
                    p_hi  <= prod[63:32];
                    p_lo  <= prod[31:0];
                    p_ok  <= 1'b1;
                    cnt   <= CW'(MULT_CYCLES);
                    state <= RUN;
                end
                is_div: begin
                    p_hi  <= rem;
                    p_lo  <= quot;
                    // Zero divisor keeps HI/LO untouched.
                    p_ok  <= ~div_zero;
                    cnt   <= CW'(DIV_CYCLES);
                    state <= RUN;
                end
                is_mthi: hi_q <= md.rs_val;
                is_mtlo: lo_q <= md.rs_val;
                default: ;
            endcase
        end
    end

    assign md.busy = (cnt != '0);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Directed cases then random ops against a cycle-count reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mult_div_unit_if md ();

    mult_div_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    // Reference state: completion edge number
    // instead of a countdown.
    int          edge_no = 0;
    bit          m_active = 0;
    int          m_done = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] m_phi = 0;
    logic [31:0] m_plo = 0;
    bit          m_pok = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    function automatic void ref_op(
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] rh,
        output logic [31:0] rl,
        output bit          ok
    );
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] u;
        sa = a;
        sb = b;
        ok = 1;
        rh = 0;
        rl = 0;
        case (op)
            MD_OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                {rh, rl} = p;
            end
            MD_OP_MULTU: begin
                u = {32'b0, a} * {32'b0, b};
                {rh, rl} = u;
            end
            MD_OP_DIV: begin
                if (b == 0) ok = 0;
                else if (a == 32'h80000000 &&
                         b == 32'hFFFFFFFF) begin
                    rl = a;
                    rh = 0;
                end else begin
                    rl = sa / sb;
                    rh = sa % sb;
                end
            end
            MD_OP_DIVU: begin
                if (b == 0) ok = 0;
                else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ok = 0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] rh;
        logic [31:0] rl;
        bit          ok;
        edge_no++;
        if (reset) begin
            m_active = 0;
            m_hi = 0;
            m_lo = 0;
        end else if (m_active) begin
            if (edge_no == m_done) begin
                m_active = 0;
                if (m_pok) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end
        end else if (md.start) begin
            case (md.op)
                MD_OP_MULT, MD_OP_MULTU,
                MD_OP_DIV, MD_OP_DIVU: begin
                    ref_op(md.op, md.rs_val, md.rt_val,
                           rh, rl, ok);
                    m_phi = rh;
                    m_plo = rl;
                    m_pok = ok;
                    m_active = 1;
                    m_done = edge_no +
                        ((md.op == MD_OP_MULT ||
                          md.op == MD_OP_MULTU) ? MC : DC);
                end
                MD_OP_MTHI: m_hi = md.rs_val;
                MD_OP_MTLO: m_lo = md.rs_val;
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", {31'b0, md.busy},
              {31'b0, m_active});
        check("hi", md.hi, m_hi);
        check("lo", md.lo, m_lo);
    endtask

    task automatic issue(input logic [2:0]  op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        md.start  = 1'b1;
        md.op     = op;
        md.rs_val = a;
        md.rt_val = b;
        step();
        md.start = 1'b0;
        md.op    = MD_OP_NONE;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        md.start  = 1'b0;
        md.op     = MD_OP_NONE;
        md.rs_val = 0;
        md.rt_val = 0;
        step();
        step();
        reset = 1'b0;

        // Signed multiply -2 * 3
        issue(MD_OP_MULT, 32'hFFFFFFFE, 32'd3);
        repeat (MC) step();
        check("mult_hi", md.hi, 32'hFFFFFFFF);
        check("mult_lo", md.lo, 32'hFFFFFFFA);

        // Unsigned multiply; old values held while busy
        issue(MD_OP_MULTU, 32'hFFFFFFFF, 32'd2);
        check("multu_hold", md.lo, 32'hFFFFFFFA);
        repeat (MC) step();
        check("multu_hi", md.hi, 32'h00000001);
        check("multu_lo", md.lo, 32'hFFFFFFFE);

        issue(MD_OP_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (DC) step();
        check("div_lo", md.lo, 32'hFFFFFFFD);
        check("div_hi", md.hi, 32'hFFFFFFFF);

        issue(MD_OP_DIVU, 32'd7, 32'd2);
        repeat (DC) step();
        check("divu_lo", md.lo, 32'd3);
        check("divu_hi", md.hi, 32'd1);

        issue(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        repeat (DC) step();
        check("ovf_lo", md.lo, 32'h80000000);
        check("ovf_hi", md.hi, 32'h0);

        // Back-to-back mthi / mtlo
        md.start  = 1'b1;
        md.op     = MD_OP_MTHI;
        md.rs_val = 32'h12345678;
        step();
        check("mthi", md.hi, 32'h12345678);
        md.op     = MD_OP_MTLO;
        md.rs_val = 32'h9ABCDEF0;
        step();
        check("mtlo", md.lo, 32'h9ABCDEF0);
        check("mt_busy", {31'b0, md.busy}, 32'd0);
        md.start = 1'b0;
        md.op    = MD_OP_NONE;

        // Zero divisor, plus an ignored mid-busy start
        issue(MD_OP_MTHI, 32'd5, 32'd0);
        issue(MD_OP_MTLO, 32'd6, 32'd0);
        issue(MD_OP_DIV, 32'd100, 32'd0);
        step();
        step();
        issue(MD_OP_MULT, 32'd2, 32'd2);
        repeat (DC - 3) step();
        check("dz_busy", {31'b0, md.busy}, 32'd0);
        check("dz_hi", md.hi, 32'd5);
        check("dz_lo", md.lo, 32'd6);

        // Reset mid-divide
        issue(MD_OP_DIV, 32'd50, 32'd7);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_busy", {31'b0, md.busy}, 32'd0);
        check("rst_hi", md.hi, 32'd0);
        repeat (DC) step();
        check("late_hi", md.hi, 32'd0);
        check("late_lo", md.lo, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            md.start  = ($urandom_range(0, 2) == 0);
            md.op     = 3'($urandom_range(0, 7));
            md.rs_val = rand_opnd();
            md.rt_val = rand_opnd();
            step();
        end
        reset    = 1'b0;
        md.start = 1'b0;
        repeat (DC + 1) step();

        $display("Result: errors=%0d of %0d checks",
                 n_errors, n_checks);
        $finish;
    end

endmodule
